// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, the store
// lane payload, and the small decode helpers used by the FSM.
package load_store_unit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MASK_W    = XLEN / 8;
  localparam int unsigned FUNCT3_W  = 3;

  // RV32I load/store funct3 encodings
  localparam logic [FUNCT3_W-1:0] LS_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] LS_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] LS_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] LS_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] LS_HU = 3'b101;

  // Write payload presented on the memory port
  typedef struct packed {
    logic [XLEN-1:0]   wdata;
    logic [MASK_W-1:0] wmask;
  } store_lanes_t;

  // Loads accept B/H/W/BU/HU; stores only B/H/W
  function automatic logic f3_legal(input logic is_store, input logic [FUNCT3_W-1:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      LS_B, LS_H, LS_W: ok = 1'b1;
      LS_BU, LS_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Alignment fault for an already-legal funct3
  function automatic logic f3_misaligned(input logic [FUNCT3_W-1:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      LS_W:         bad = (lo != 2'b00);
      LS_H, LS_HU:  bad = lo[0];
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Replicate store data across lanes and select the byte enables
  function automatic store_lanes_t store_lanes(input logic [FUNCT3_W-1:0] f3,
                                               input logic [1:0] lo,
                                               input logic [XLEN-1:0] wdata);
    store_lanes_t s;
    s.wdata = wdata;
    s.wmask = 4'b1111;
    case (f3)
      LS_B: begin
        s.wdata = {4{wdata[7:0]}};
        s.wmask = 4'(4'b0001 << lo);
      end
      LS_H: begin
        s.wdata = {2{wdata[15:0]}};
        s.wmask = lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        s.wdata = wdata;
        s.wmask = 4'b1111;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/load_store_unit_load_aligner.sv
// Combinational load data extraction: picks the addressed byte/half out of
// the read word and sign- or zero-extends it according to funct3.
//   mem_rdata : raw 32-bit word from memory
//   addr_lo   : byte offset within the word
//   funct3    : load type
//   result_c  : extended write-back value
module load_aligner
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic [1:0]          addr_lo,
  input  logic [FUNCT3_W-1:0] funct3,
  output logic [XLEN-1:0]     result_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Lane select
  always_comb begin
    byte_c = mem_rdata[7:0];
    case (addr_lo)
      2'd0: byte_c = mem_rdata[7:0];
      2'd1: byte_c = mem_rdata[15:8];
      2'd2: byte_c = mem_rdata[23:16];
      2'd3: byte_c = mem_rdata[31:24];
      default: byte_c = mem_rdata[7:0];
    endcase
    half_c = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Extension
  always_comb begin
    result_c = '0;
    case (funct3)
      LS_B:    result_c = {{24{byte_c[7]}}, byte_c};
      LS_H:    result_c = {{16{half_c[15]}}, half_c};
      LS_W:    result_c = mem_rdata;
      LS_BU:   result_c = {24'd0, byte_c};
      LS_HU:   result_c = {16'd0, half_c};
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage. Accepts one load/store from EXECUTE, checks
// funct3 legality and alignment, issues a single word-addressed request with
// byte mask over a valid/ready port, and returns load data with a done pulse.
//   clk, reset          : clock, synchronous active-high reset
//   start, is_store,
//   funct3, addr,
//   wdata_in            : request from the core, sampled on start in IDLE
//   busy, done          : status; done is a one-cycle completion pulse
//   rdata_out           : extended load result, held until the next load
//   misaligned, illegal : fault qualifiers, valid with done
//   mem_*               : memory port (valid/ready, word address, mask)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [FUNCT3_W-1:0]   funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [XLEN-1:0]       wdata_in,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       rdata_out,
  output logic                  misaligned,
  output logic                  illegal,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [MASK_W-1:0]     mem_wmask,
  input  logic [XLEN-1:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [FUNCT3_W-1:0]   funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  misaligned_q, misaligned_d;
  logic                  illegal_q, illegal_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0]     mem_wmask_q, mem_wmask_d;

  logic [XLEN-1:0]       load_result_c;
  store_lanes_t          lanes_c;

  load_aligner u_load_aligner (
    .mem_rdata (mem_rdata),
    .addr_lo   (addr_lo_q),
    .funct3    (funct3_q),
    .result_c  (load_result_c)
  );

  assign lanes_c = store_lanes(funct3, addr[1:0], wdata_in);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    rdata_d      = rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    misaligned_d = 1'b0;
    illegal_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          addr_lo_d  = addr[1:0];
          if (!f3_legal(is_store, funct3)) begin
            state_d   = RESP;
            illegal_d = 1'b1;
          end else if (f3_misaligned(funct3, addr[1:0])) begin
            state_d      = RESP;
            misaligned_d = 1'b1;
          end else begin
            // Port payload is captured once here and held until the handshake
            state_d     = ACCESS;
            mem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = lanes_c.wdata;
            mem_wmask_d = is_store ? lanes_c.wmask : 4'b0000;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d = RESP;
          if (!is_store_q) begin
            rdata_d = load_result_c;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags follow the state being entered so they are registered
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == RESP);
    mem_valid_d = (state_d == ACCESS);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      mem_valid_q  <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
      mem_valid_q  <= mem_valid_d;
      rdata_q      <= rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign misaligned = misaligned_q;
  assign illegal    = illegal_q;
  assign mem_valid  = mem_valid_q;
  assign rdata_out  = rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, randomized operations
// against a behavioural reference model, and a mid-access reset sequence.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          is_store;
  logic [2:0]    funct3;
  logic [AW-1:0] addr;
  logic [31:0]   wdata_in;
  logic          busy;
  logic          done;
  logic [31:0]   rdata_out;
  logic          misaligned;
  logic          illegal;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_rdata;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata_in   (wdata_in),
    .busy       (busy),
    .done       (done),
    .rdata_out  (rdata_out),
    .misaligned (misaligned),
    .illegal    (illegal),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          delay;   // cycles mem_ready stays low while mem_valid is high
    bit          spam;    // pulse start while busy
  } op_t;

  typedef struct {
    int          cyc;     // done cycle relative to start cycle
    bit          mis;
    bit          ill;
    bit          valid;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata;
  vec_t        vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model written from the architectural rules
  function automatic exp_t model(input op_t op, input logic [31:0] prev);
    exp_t        e;
    bit          legal;
    int unsigned size;
    int unsigned k;
    logic [31:0] b;
    logic [31:0] h;
    legal = op.st ? (op.f3 <= 3'd2) : (op.f3 <= 3'd2 || op.f3 == 3'd4 || op.f3 == 3'd5);
    size  = (op.f3[1:0] == 2'd2) ? 4 : (op.f3[1:0] == 2'd1) ? 2 : 1;
    e.cyc = 1; e.mis = 0; e.ill = 0; e.valid = 0;
    e.maddr = 0; e.wdata = 0; e.wmask = 0; e.rdata = prev;
    if (!legal) begin
      e.ill = 1;
    end else if (op.addr % size != 0) begin
      e.mis = 1;
    end else begin
      e.valid = 1;
      e.cyc   = 2 + op.delay;
      k       = op.addr % 4;
      e.maddr = op.addr - k;
      if (op.st) begin
        if (size == 1) begin
          e.wdata = (op.wdata & 32'hFF) * 32'h01010101;
          e.wmask = 4'(1 << k);
        end else if (size == 2) begin
          e.wdata = (op.wdata & 32'hFFFF) * 32'h00010001;
          e.wmask = 4'(3 << k);
        end else begin
          e.wdata = op.wdata;
          e.wmask = 4'hF;
        end
      end else begin
        b = (op.rword >> (8 * k)) & 32'hFF;
        h = (op.rword >> (8 * k)) & 32'hFFFF;
        case (op.f3)
          3'd0:    e.rdata = (b >= 128) ? (b | 32'hFFFFFF00) : b;
          3'd1:    e.rdata = (h >= 32768) ? (h | 32'hFFFF0000) : h;
          3'd2:    e.rdata = op.rword;
          3'd4:    e.rdata = b;
          default: e.rdata = h;
        endcase
      end
    end
    return e;
  endfunction

  function automatic vec_t mk(input bit st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rw, input int dl,
                              input bit sp, input int cyc, input bit mis, input bit ill,
                              input bit vl, input logic [31:0] ma, input logic [31:0] ewd,
                              input logic [3:0] wm, input logic [31:0] rd);
    vec_t v;
    v.op.st = st; v.op.f3 = f3; v.op.addr = a; v.op.wdata = wd; v.op.rword = rw;
    v.op.delay = dl; v.op.spam = sp;
    v.e.cyc = cyc; v.e.mis = mis; v.e.ill = ill; v.e.valid = vl;
    v.e.maddr = ma; v.e.wdata = ewd; v.e.wmask = wm; v.e.rdata = rd;
    return v;
  endfunction

  // Issue one operation, act as the memory, and compare everything observed
  task automatic run_op(input op_t op, input exp_t e, input string tag);
    int          cyc;
    int          vcnt;
    int          dcyc;
    bit          got_done;
    bit          seen_valid;
    bit          unstable;
    bit          busy_bad;
    logic [31:0] maddr, wd, rd;
    logic [3:0]  wm;
    logic        mis, ill;
    cyc = 0; vcnt = 0; dcyc = 0; got_done = 0; seen_valid = 0; unstable = 0; busy_bad = 0;
    maddr = 0; wd = 0; wm = 0; rd = 0; mis = 0; ill = 0;
    @(negedge clk);
    check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    start = 1; is_store = op.st; funct3 = op.f3; addr = op.addr; wdata_in = op.wdata;
    mem_rdata = op.rword; mem_ready = (op.delay == 0);
    while (!got_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 0;
      if (busy !== 1'b1) busy_bad = 1;
      if (mem_valid === 1'b1) begin
        vcnt++;
        if (!seen_valid) begin
          maddr = mem_addr; wd = mem_wdata; wm = mem_wmask;
        end else if (mem_addr !== maddr || mem_wdata !== wd || mem_wmask !== wm) begin
          unstable = 1;
        end
        seen_valid = 1;
      end
      if (done === 1'b1) begin
        got_done = 1; dcyc = cyc; rd = rdata_out; mis = misaligned; ill = illegal;
      end else begin
        mem_ready = (vcnt > op.delay);
        if (op.spam) begin
          start = 1; is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom;
        end
      end
    end
    start = 0; mem_ready = 0;
    if (!got_done) begin
      check({tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, ".done_cycle"}, dcyc, e.cyc);
      check({tag, ".misaligned"}, 32'(mis), 32'(e.mis));
      check({tag, ".illegal"}, 32'(ill), 32'(e.ill));
      check({tag, ".mem_valid_seen"}, 32'(seen_valid), 32'(e.valid));
      check({tag, ".busy"}, 32'(busy_bad), 32'd0);
      check({tag, ".rdata_out"}, rd, e.rdata);
      if (e.valid) begin
        check({tag, ".mem_addr"}, maddr, e.maddr);
        check({tag, ".mem_wmask"}, 32'(wm), 32'(e.wmask));
        check({tag, ".stable"}, 32'(unstable), 32'd0);
        if (op.st) check({tag, ".mem_wdata"}, wd, e.wdata);
      end
    end
  endtask

  initial begin
    op_t  op;
    exp_t e;
    reset = 1; start = 0; is_store = 0; funct3 = 0; addr = 0; wdata_in = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.status", {27'd0, busy, done, misaligned, illegal, mem_valid}, 32'd0);
    check("reset.rdata_out", rdata_out, 32'd0);
    check("reset.mem_addr", mem_addr, 32'd0);
    check("reset.mem_wdata", mem_wdata, 32'd0);
    check("reset.mem_wmask", 32'(mem_wmask), 32'd0);
    reset = 0;

    vecs[0]  = mk(0, LS_W,  32'h104, 0, 32'hDEADBEEF, 0, 0, 2, 0, 0, 1, 32'h104, 0, 4'b0000, 32'hDEADBEEF);
    vecs[1]  = mk(0, LS_B,  32'h103, 0, 32'h80FF1234, 0, 0, 2, 0, 0, 1, 32'h100, 0, 4'b0000, 32'hFFFFFF80);
    vecs[2]  = mk(0, LS_BU, 32'h103, 0, 32'h80FF1234, 0, 0, 2, 0, 0, 1, 32'h100, 0, 4'b0000, 32'h00000080);
    vecs[3]  = mk(1, LS_H,  32'h22, 32'h0000ABCD, 0, 0, 0, 2, 0, 0, 1, 32'h20, 32'hABCDABCD, 4'b1100, 32'h80);
    vecs[4]  = mk(0, LS_W,  32'h101, 0, 32'h55, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h80);
    vecs[5]  = mk(1, LS_H,  32'h23, 32'h1234, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h80);
    vecs[6]  = mk(0, 3'b011, 32'h10, 0, 32'h55, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h80);
    vecs[7]  = mk(1, LS_B,  32'h41, 32'h5A, 0, 5, 1, 7, 0, 0, 1, 32'h40, 32'h5A5A5A5A, 4'b0010, 32'h80);
    vecs[8]  = mk(0, LS_H,  32'h102, 0, 32'h80010000, 0, 0, 2, 0, 0, 1, 32'h100, 0, 4'b0000, 32'hFFFF8001);
    vecs[9]  = mk(0, LS_HU, 32'h100, 0, 32'h1234F00D, 0, 0, 2, 0, 0, 1, 32'h100, 0, 4'b0000, 32'h0000F00D);
    vecs[10] = mk(1, LS_BU, 32'h0, 32'hFF, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'hF00D);
    vecs[11] = mk(1, LS_W,  32'h8, 32'h11223344, 0, 0, 0, 2, 0, 0, 1, 32'h8, 32'h11223344, 4'b1111, 32'hF00D);
    vecs[12] = mk(1, 3'b111, 32'h3, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'hF00D);
    vecs[13] = mk(0, LS_W,  32'h200, 0, 32'hCAFEF00D, 3, 0, 5, 0, 0, 1, 32'h200, 0, 4'b0000, 32'hCAFEF00D);
    vecs[14] = mk(0, LS_B,  32'h201, 0, 32'h00007F00, 0, 0, 2, 0, 0, 1, 32'h200, 0, 4'b0000, 32'h0000007F);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].op, vecs[i].e, $sformatf("vec%0d", i));
    end
    model_rdata = vecs[14].e.rdata;

    for (int i = 0; i < 150; i++) begin
      op.st    = 1'($urandom);
      op.f3    = 3'($urandom);
      op.addr  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1) * 2);
      op.wdata = $urandom;
      op.rword = $urandom;
      op.delay = $urandom_range(0, 3);
      op.spam  = 1'($urandom);
      e = model(op, model_rdata);
      run_op(op, e, $sformatf("rnd%0d", i));
      model_rdata = e.rdata;
    end

    // Reset while waiting in ACCESS abandons the request
    @(negedge clk);
    start = 1; is_store = 0; funct3 = LS_W; addr = 32'h300; mem_rdata = 32'h12345678; mem_ready = 0;
    @(negedge clk);
    start = 0;
    check("rst_mid.mem_valid_before", 32'(mem_valid), 32'd1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("rst_mid.status", {29'd0, mem_valid, busy, done}, 32'd0);
    check("rst_mid.rdata_out", rdata_out, 32'd0);
    check("rst_mid.mem_addr", mem_addr, 32'd0);
    reset = 0;
    model_rdata = 0;
    op.st = 0; op.f3 = LS_W; op.addr = 32'h400; op.wdata = 0; op.rword = 32'hA5A5_1234;
    op.delay = 1; op.spam = 0;
    e = model(op, model_rdata);
    run_op(op, e, "rst_mid.after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the core's EXECUTE state. It runs RV32I LB/LH/LW/LBU/LHU/SB/SH/SW using the effective address (rs1+imm) and rs2 computed there. It drives a word-addressed memory port with byte write-mask and a valid/ready handshake. It returns write-back data for loads to the core with a one-cycle done pulse.

Parameters:
ADDR_WIDTH, 32, width of the byte address in and of mem_addr out.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request from core EXECUTE (isLoad or isStore)
is_store  in  1  1 = store, 0 = load; sampled with start
funct3  in  3  instr[14:12]; sampled with start
addr  in  ADDR_WIDTH  effective byte address; sampled with start
wdata_in  in  32  rs2 value; sampled with start
busy  out  1  high from cycle after accepted start until done cycle inclusive
done  out  1  one-cycle completion pulse
rdata_out  out  32  extended load result; valid while done=1
misaligned  out  1  qualifies done: access not issued, alignment fault
illegal  out  1  qualifies done: unsupported funct3, access not issued
mem_valid  out  1  memory request valid
mem_ready  in  1  memory accepts or completes request
mem_addr  out  ADDR_WIDTH  {addr[ADDR_WIDTH-1:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wmask  out  4  byte enables; 4'b0000 for loads
mem_rdata  in  32  read word; sampled on the handshake cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset, including mid-operation: state=IDLE. busy, done, misaligned, illegal and mem_valid are 0. rdata_out, mem_addr, mem_wdata and mem_wmask are 0. An in-flight request is abandoned and mem_valid drops on the next edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On start, latch is_store, funct3, addr and wdata_in.
  - If funct3 is illegal, go to RESP with illegal=1. Legal loads are 000, 001, 010, 100, 101. Legal stores are 000, 001, 010.
  - Else if misaligned, go to RESP with misaligned=1. Misaligned means word access with addr[1:0]!=0, or half access with addr[0]!=0.
  - Otherwise go to ACCESS.
  - start is ignored in every state except IDLE.
- ACCESS:
  - mem_valid=1. mem_addr, mem_wdata and mem_wmask are registered and held stable until the handshake.
  - Handshake is mem_valid && mem_ready. On it, loads register the extracted result into rdata_out, then go to RESP.
  - No timeout; waits indefinitely.
- RESP: done=1 for exactly one cycle, then IDLE. rdata_out holds until the next load completes. misaligned and illegal are asserted only in RESP.
- Latency: with mem_ready high, start at cycle N gives the handshake at N+1 and done at N+2. Fault paths give done at N+1. A new start is accepted the cycle after done, so throughput is 1 access per 3 cycles minimum.
- Store lanes (k = addr[1:0]):
  - SB: wdata={4{wdata_in[7:0]}}, mask=4'b0001<<k.
  - SH: wdata={2{wdata_in[15:0]}}, mask=4'b0011<<(2*addr[1]).
  - SW: wdata=wdata_in, mask=4'b1111.
- Load extraction:
  - byte = mem_rdata[8k+7:8k]; half = mem_rdata[16*addr[1]+15:16*addr[1]].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- Stores leave rdata_out unchanged. Faulted accesses leave rdata_out unchanged and never assert mem_valid.

Decomposition:
- Shared include file holds funct3 localparams: LS_B=3'b000, LS_H=3'b001, LS_W=3'b010, LS_BU=3'b100, LS_HU=3'b101. The decoder and bench use the same file.
- FSM state localparams (IDLE, ACCESS, RESP) stay local to the module.
- One natural sub-module: load_aligner. It is combinational: mem_rdata, addr[1:0] and funct3 in; 32-bit extended result out.

Test Plan:
- LW addr=0x104, mem_rdata=0xDEADBEEF, mem_ready tied 1 -> mem_valid at N+1, mem_addr=0x104, mem_wmask=0000; done at N+2 with rdata_out=0xDEADBEEF, busy high N+1..N+2.
- LB addr=0x103 and LBU addr=0x103, mem_rdata=0x80FF1234 -> rdata_out=0xFFFFFF80 for LB; rdata_out=0x00000080 for LBU.
- SH addr=0x22, wdata_in=0x0000ABCD -> mem_addr=0x20, mem_wdata=0xABCDABCD, mem_wmask=1100; done with misaligned=0.
- LW addr=0x101 and SH addr=0x23 -> done at N+1 with misaligned=1, mem_valid never high; funct3=3'b011 load -> done with illegal=1.
- SB addr=0x41 with mem_ready held 0 for 5 cycles -> mem_valid, mem_wdata and mem_wmask=0010 stable all 5 cycles; done 1 cycle after mem_ready rises; start pulses during busy ignored.
- reset asserted while in ACCESS -> next cycle mem_valid=0, busy=0, done=0; a following LW completes normally.
